// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// It uses radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow complete in a single cycle.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  cnt;

    // Operation context captured at accept
    logic [2:0]        op;
    logic              neg_main;   // negate product / quotient
    logic              neg_rem;    // remainder follows the dividend sign
    logic [XLEN-1:0]   mag_b;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc;        // product accumulator, or dividend/quotient in the low half
    logic [XLEN:0]     rem;        // partial remainder

    // Incoming operand decode
    logic              accept;
    logic              op1_signed;
    logic              op2_signed;
    logic              op1_neg;
    logic              op2_neg;
    logic [XLEN-1:0]   op1_mag;
    logic [XLEN-1:0]   op2_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_val;

    // One iteration step
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN+1:0]   rem_shift;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quo_next;

    // Sign correction and result selection from unsigned magnitudes
    function automatic logic [XLEN-1:0] finish_result(
        input logic [2:0]        f,
        input logic [2*XLEN-1:0] prod,
        input logic [XLEN-1:0]   quo,
        input logic [XLEN-1:0]   rmd,
        input logic              neg_m,
        input logic              neg_r
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        p = neg_m ? -prod : prod;
        q = neg_m ? -quo  : quo;
        r = neg_r ? -rmd  : rmd;
        if (!f[2])
            finish_result = (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        else
            finish_result = f[1] ? r : q;
    endfunction

    assign in_ready   = (state == S_IDLE);
    assign accept     = in_valid && (state == S_IDLE) && !kill;

    assign op1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign op2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign op1_neg    = op1_signed && op1[XLEN-1];
    assign op2_neg    = op2_signed && op2[XLEN-1];
    assign op1_mag    = op1_neg ? -op1 : op1;
    assign op2_mag    = op2_neg ? -op2 : op2;

    assign div_zero   = funct3[2] && (op2 == '0);
    assign div_ovf    = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                        (op1 == MIN_NEG) && (op2 == ALL_ONES);
    assign fast_hit   = div_zero || div_ovf;

    // Single-cycle results: divide by zero and the signed overflow case
    always_comb begin
        fast_val = '0;
        if (div_zero)
            fast_val = funct3[1] ? op1 : ALL_ONES;
        else if (div_ovf)
            fast_val = funct3[1] ? '0 : op1;
    end

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};

    assign rem_shift = {rem, acc[XLEN-1]};
    assign div_diff  = rem_shift - {2'b00, mag_b};
    assign div_ge    = !div_diff[XLEN+1];
    assign rem_next  = div_ge ? div_diff[XLEN:0] : rem_shift[XLEN:0];
    assign quo_next  = {acc[XLEN-2:0], div_ge};

    // Next-state decode; kill overrides everything
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = fast_hit ? S_DONE : S_RUN;
            S_RUN:   if (cnt == CNT_W'(1)) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (kill)
            state_next = S_IDLE;
    end

    // Control and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next == S_DONE);
            busy      <= (state_next != S_IDLE);
            if (accept) begin
                cnt <= CNT_W'(XLEN);
                if (fast_hit)
                    result <= fast_val;
            end else if (state == S_RUN) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1) && !kill)
                    result <= finish_result(op, mul_next, quo_next, rem_next[XLEN-1:0],
                                            neg_main, neg_rem);
            end
        end
    end

    // Datapath: load magnitudes at accept, then one bit per RUN cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            op       <= funct3;
            neg_main <= op1_neg ^ op2_neg;
            neg_rem  <= op1_neg;
            rem      <= '0;
            if (funct3[2]) begin
                mag_b <= op2_mag;
                acc   <= {{XLEN{1'b0}}, op1_mag};
            end else begin
                mag_b <= op1_mag;
                acc   <= {{XLEN{1'b0}}, op2_mag};
            end
        end else if (state == S_RUN) begin
            if (op[2]) begin
                acc <= {acc[2*XLEN-1:XLEN], quo_next};
                rem <= rem_next;
            end else begin
                acc <= mul_next;
            end
        end
    end

endmodule
